// File: rtl/noc_rx_arbiter_pkg.sv
// Shared types and helpers for the receive-side arbiter and its round-robin picker.
package noc_rx_arbiter_pkg;

  // Width of the accepted-packet counter.
  localparam int unsigned CNT_W = 16;

  // Arbiter control states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    FLUSH   = 2'd2
  } e_rx_arb_state;

  // Index reached by stepping 'off' places past 'base' on a ring of 'n' entries.
  function automatic int unsigned rr_wrap(input int unsigned base,
                                          input int unsigned off,
                                          input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/noc_rx_arbiter_rr.sv
// Combinational rotate-priority arbiter: first request after 'last', wrapping.
module noc_rr_arbiter
  import noc_rx_arbiter_pkg::*;
#(
  parameter  int unsigned N     = 4,
  localparam int unsigned SRC_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [SRC_W-1:0] i_last,
  output logic [N-1:0]     o_gnt_onehot_c,
  output logic [SRC_W-1:0] o_gnt_idx_c,
  output logic             o_any_c
);

  // Scan from last+1 around the ring; the first hit wins.
  always_comb begin
    o_gnt_onehot_c = '0;
    o_gnt_idx_c    = '0;
    o_any_c        = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      logic [SRC_W-1:0] v_sel;
      v_sel = SRC_W'(rr_wrap(32'(i_last), k, N));
      if (!o_any_c && i_req[v_sel]) begin
        o_any_c               = 1'b1;
        o_gnt_idx_c           = v_sel;
        o_gnt_onehot_c[v_sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_rx_arbiter.sv
// Shares one valid/ready consumer among N_RX serial receivers, round-robin,
// and flushes the granted receiver once its packet has been accepted.
module noc_rx_arbiter
  import noc_rx_arbiter_pkg::*;
#(
  parameter  int unsigned N_RX         = 4,
  parameter  int unsigned PACKET_BITS  = 16,
  parameter  int unsigned PADDING_BITS = 1,
  localparam int unsigned SRC_W        = $clog2(N_RX)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_RX-1:0]              i_rx_valid,
  input  logic [N_RX*PACKET_BITS-1:0]  i_rx_packet,
  input  logic [N_RX*PADDING_BITS-1:0] i_rx_padding,
  input  logic [N_RX-1:0]              i_rx_mask,
  output logic [N_RX-1:0]              o_rx_flush,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [PACKET_BITS-1:0]       o_out_packet,
  output logic [PADDING_BITS-1:0]      o_out_padding,
  output logic [SRC_W-1:0]             o_out_src,
  output logic [CNT_W-1:0]             o_pkt_count
);

  e_rx_arb_state           r_state;
  e_rx_arb_state           w_state_nxt;
  logic                    w_load;
  logic                    w_accept;

  logic [N_RX-1:0]         w_req;
  logic [N_RX-1:0]         w_gnt_onehot;
  logic [SRC_W-1:0]        w_gnt_idx;
  logic                    w_any;
  logic [PACKET_BITS-1:0]  w_pkt;
  logic [PADDING_BITS-1:0] w_pad;
  logic [N_RX-1:0]         w_flush_vec;

  logic [N_RX-1:0]         r_rx_flush;
  logic                    r_out_valid;
  logic [PACKET_BITS-1:0]  r_out_packet;
  logic [PADDING_BITS-1:0] r_out_padding;
  logic [SRC_W-1:0]        r_out_src;
  logic [SRC_W-1:0]        r_last_grant;
  logic [CNT_W-1:0]        r_pkt_count;

  // Masked-off receivers keep their packet and are simply not considered.
  assign w_req = i_rx_valid & i_rx_mask;

  noc_rr_arbiter #(
    .N (N_RX)
  ) u_rr (
    .i_req          (w_req),
    .i_last         (r_last_grant),
    .o_gnt_onehot_c (w_gnt_onehot),
    .o_gnt_idx_c    (w_gnt_idx),
    .o_any_c        (w_any)
  );

  // One-hot AND-OR select of the winning receiver's packet and padding.
  always_comb begin
    w_pkt = '0;
    w_pad = '0;
    for (int unsigned i = 0; i < N_RX; i++) begin
      if (w_gnt_onehot[i]) begin
        w_pkt = w_pkt | i_rx_packet[i*PACKET_BITS +: PACKET_BITS];
        w_pad = w_pad | i_rx_padding[i*PADDING_BITS +: PADDING_BITS];
      end
    end
  end

  assign w_flush_vec = N_RX'(1) << r_out_src;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus load/accept strobes for the datapath registers.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_load      = 1'b1;
          w_state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (i_out_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output port, flush pulse, priority pointer and counter; a reset drops any
  // held packet and kills a pending flush so the receiver is re-arbitrated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_packet  <= '0;
      r_out_padding <= '0;
      r_out_src     <= '0;
      r_rx_flush    <= '0;
      r_last_grant  <= SRC_W'(N_RX - 1);
      r_pkt_count   <= '0;
    end else begin
      r_rx_flush <= w_accept ? w_flush_vec : '0;
      if (w_load) begin
        r_out_valid   <= 1'b1;
        r_out_packet  <= w_pkt;
        r_out_padding <= w_pad;
        r_out_src     <= w_gnt_idx;
      end else if (w_accept) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        r_last_grant <= r_out_src;
        r_pkt_count  <= r_pkt_count + CNT_W'(1);
      end
    end
  end

  assign o_rx_flush    = r_rx_flush;
  assign o_out_valid   = r_out_valid;
  assign o_out_packet  = r_out_packet;
  assign o_out_padding = r_out_padding;
  assign o_out_src     = r_out_src;
  assign o_pkt_count   = r_pkt_count;

endmodule

// File: tb/tb_noc_rx_arbiter.sv
// Randomized and directed bench for noc_rx_arbiter with a transaction-level
// reference model feeding an expected-grant queue.
module tb_noc_rx_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned PB = 16;
  localparam int unsigned PD = 1;
  localparam int unsigned SW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      rx_valid;
  logic [N*PB-1:0]   rx_packet;
  logic [N*PD-1:0]   rx_padding;
  logic [N-1:0]      rx_mask;
  logic [N-1:0]      rx_flush;
  logic              out_valid;
  logic              out_ready;
  logic [PB-1:0]     out_packet;
  logic [PD-1:0]     out_padding;
  logic [SW-1:0]     out_src;
  logic [15:0]       pkt_count;

  noc_rx_arbiter #(
    .N_RX         (N),
    .PACKET_BITS  (PB),
    .PADDING_BITS (PD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_rx_valid    (rx_valid),
    .i_rx_packet   (rx_packet),
    .i_rx_padding  (rx_padding),
    .i_rx_mask     (rx_mask),
    .o_rx_flush    (rx_flush),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_out_packet  (out_packet),
    .o_out_padding (out_padding),
    .o_out_src     (out_src),
    .o_pkt_count   (pkt_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [SW-1:0] src;
    logic [PB-1:0] pkt;
    logic [PD-1:0] pad;
  } exp_t;

  exp_t         exp_q[$];
  int           grant_log[$];
  int           m_phase;   // 0 waiting for requests, 1 packet offered, 2 flush cycle
  int unsigned  m_last;
  int unsigned  m_src;
  logic [N-1:0] m_flush;
  logic [15:0]  m_cnt;

  // Round-robin choice from the rules: first requester after 'last', wrapping.
  function automatic int pick(input logic [N-1:0] req, input int unsigned last);
    for (int unsigned k = 1; k <= N; k++) begin
      int unsigned idx;
      idx = (last + k) % N;
      if (req[idx]) return int'(idx);
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_last  = N - 1;
      m_cnt   = '0;
      m_flush = '0;
      exp_q.delete();
    end else begin
      m_flush = '0;
      if (m_phase == 0) begin
        int g;
        exp_t e;
        g = pick(rx_valid & rx_mask, m_last);
        if (g >= 0) begin
          m_src = 32'(g);
          e.src = SW'(g);
          e.pkt = rx_packet[g*PB +: PB];
          e.pad = rx_padding[g*PD +: PD];
          exp_q.push_back(e);
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (out_ready) begin
          m_cnt          = m_cnt + 16'd1;
          m_last         = m_src;
          m_flush[m_src] = 1'b1;
          m_phase        = 2;
        end
      end else begin
        m_phase = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  exp_t cur;
  bit   mon_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      mon_prev = 1'b0;
    end else begin
      check("out_valid", 64'(out_valid), 64'(m_phase == 1));
      check("rx_flush", 64'(rx_flush), 64'(m_flush));
      check("pkt_count", 64'(pkt_count), 64'(m_cnt));
      if (out_valid && !mon_prev) begin
        check("exp_q_nonempty", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          grant_log.push_back(int'(cur.src));
        end
      end
      if (out_valid) begin
        check("out_src", 64'(out_src), 64'(cur.src));
        check("out_packet", 64'(out_packet), 64'(cur.pkt));
        check("out_padding", 64'(out_padding), 64'(cur.pad));
      end
      mon_prev = out_valid;
    end
  end

  // ---------------- stimulus ----------------
  int unsigned p_refill  = 0;
  bit          rand_rdy  = 1'b0;
  bit          rand_mask = 1'b0;

  task automatic load_rx(input int i, input logic [PB-1:0] pkt, input logic [PD-1:0] pad);
    rx_packet[i*PB +: PB]  = pkt;
    rx_padding[i*PD +: PD] = pad;
    rx_valid[i]            = 1'b1;
  endtask

  // One cycle of receiver behaviour: a flushed receiver drops valid and may
  // later be refilled with a fresh random packet.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < int'(N); i++) begin
      if (rx_flush[i]) rx_valid[i] = 1'b0;
      else if (!rx_valid[i] && ($urandom_range(99) < p_refill))
        load_rx(i, PB'($urandom), PD'($urandom));
    end
    if (rand_rdy) out_ready = ($urandom_range(99) < 70);
    if (rand_mask && ($urandom_range(99) < 10)) rx_mask = N'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    grant_log.delete();
  endtask

  initial begin
    int pulses;
    logic [SW-1:0] held_src;
    rst        = 1'b1;
    rx_valid   = '0;
    rx_packet  = '0;
    rx_padding = '0;
    rx_mask    = '1;
    out_ready  = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_rx_flush", 64'(rx_flush), 64'(0));
    check("rst_pkt_count", 64'(pkt_count), 64'(0));
    check("rst_out_src", 64'(out_src), 64'(0));
    check("rst_out_packet", 64'(out_packet), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Single request on source 2.
    load_rx(2, 16'hA5C3, 1'b1);
    step();
    check("t1_valid", 64'(out_valid), 64'(1));
    check("t1_src", 64'(out_src), 64'(2));
    check("t1_packet", 64'(out_packet), 64'hA5C3);
    step();
    check("t1_flush", 64'(rx_flush), 64'(4'b0100));
    check("t1_count", 64'(pkt_count), 64'(1));
    repeat (3) step();

    // All four requesting continuously.
    do_reset();
    p_refill = 100;
    for (int i = 0; i < int'(N); i++) load_rx(i, PB'($urandom), PD'($urandom));
    repeat (15) step();
    check("t2_count", 64'(pkt_count), 64'(5));
    check("t2_ngrants", 64'(grant_log.size()), 64'(5));
    for (int i = 0; i < 5; i++)
      if (i < grant_log.size()) check("t2_order", 64'(grant_log[i]), 64'(i % 4));
    p_refill = 0;
    repeat (10) step();

    // Back-pressure for ten cycles.
    do_reset();
    out_ready = 1'b0;
    load_rx(1, 16'h1234, 1'b0);
    step();
    held_src = out_src;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t3_hold_valid", 64'(out_valid), 64'(1));
      check("t3_hold_src", 64'(out_src), 64'(1));
    end
    out_ready = 1'b1;
    step();
    check("t3_flush", 64'(rx_flush), 64'(4'b0010));
    pulses = 0;
    repeat (4) begin
      step();
      if (rx_flush != '0) pulses++;
    end
    check("t3_extra_flush", 64'(pulses), 64'(0));
    check("t3_src_held", 64'(held_src), 64'(1));

    // Masked receiver is skipped until unmasked.
    do_reset();
    rx_mask = 4'b0010;
    load_rx(0, PB'($urandom), 1'b0);
    load_rx(1, PB'($urandom), 1'b1);
    repeat (10) step();
    check("t4_ngrants", 64'(grant_log.size()), 64'(1));
    check("t4_rx0_kept", 64'(rx_valid[0]), 64'(1));
    rx_mask = 4'hF;
    repeat (5) step();
    check("t4_ngrants2", 64'(grant_log.size()), 64'(2));
    if (grant_log.size() == 2) check("t4_second", 64'(grant_log[1]), 64'(0));

    // Reset while a packet is on offer.
    do_reset();
    out_ready = 1'b0;
    load_rx(3, 16'hBEEF, 1'b1);
    step();
    check("t5_pre_valid", 64'(out_valid), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("t5_async_valid", 64'(out_valid), 64'(0));
    check("t5_async_flush", 64'(rx_flush), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    grant_log.delete();
    out_ready = 1'b1;
    step();
    check("t5_regrant_src", 64'(out_src), 64'(3));
    check("t5_count0", 64'(pkt_count), 64'(0));
    step();
    check("t5_count1", 64'(pkt_count), 64'(1));
    repeat (3) step();

    // Random traffic with random ready and mask churn.
    do_reset();
    p_refill  = 30;
    rand_rdy  = 1'b1;
    rand_mask = 1'b1;
    repeat (3000) step();
    p_refill  = 0;
    rand_rdy  = 1'b0;
    rand_mask = 1'b0;
    rx_mask   = 4'hF;
    out_ready = 1'b1;
    repeat (40) step();
    check("drain_rx_valid", 64'(rx_valid), 64'(0));
    check("drain_exp_q", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
